nios2_secure_memory_button_pio: RTL and testbench

// - Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO.
// - Samples an external WIDTH-bit input bus (push buttons / switches).
// - Provides a data register, a per-bit edge-capture register and an interrupt mask.
// - Drives a level IRQ to the Nios II; sits on the same system interconnect as the LED PIO.

---
 rtl/nios2_secure_memory_pio_pkg.sv | 15 +
 rtl/nios2_secure_memory_pio_edge_detect.sv | 55 +++++
 rtl/nios2_secure_memory_button_pio.sv | 79 +++++++
 tb/tb_nios2_secure_memory_button_pio.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nios2_secure_memory_pio_pkg.sv
// Shared constants for the button/switch input PIO: register map and edge modes.
package nios2_secure_memory_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_DIR     = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios2_secure_memory_pio_edge_detect.sv
// Input conditioning for the PIO: synchroniser chain, one-cycle-delayed copy,
// per-bit edge select, and a short warm-up window after reset during which
// edges are suppressed so inputs already high at release are not reported.
module nios2_secure_memory_pio_edge_detect
  import nios2_secure_memory_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_FALLING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] sel
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARMUP = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] warm_cnt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Synchroniser shift, previous-sample flop and warm-up countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev     <= '0;
      warm_cnt <= WARMUP;
    end else begin
      sync_ff[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync_ff[SYNC_STAGES-1];
      if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
    end
  end

  // Edge select by configured polarity, gated off until warm-up expires.
  always_comb begin
    rise = sync & ~prev;
    fall = ~sync & prev;
    case (EDGE_TYPE)
      EDGE_RISING:  sel = rise;
      EDGE_FALLING: sel = fall;
      default:      sel = rise | fall;
    endcase
    if (warm_cnt != '0) sel = '0;
  end

endmodule

// File: rtl/nios2_secure_memory_button_pio.sv
// Avalon-MM input PIO for push buttons / switches: data, irq mask and
// write-1-to-clear edge-capture registers, with a registered level irq.
module nios2_secure_memory_button_pio
  import nios2_secure_memory_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_FALLING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             rd_en;
  logic             wr_en;
  pio_addr_e        addr_e;

  assign addr_e = pio_addr_e'(address);
  assign rd_en  = chipselect & ~read_n;
  assign wr_en  = chipselect & ~write_n;
  assign wdata  = writedata[WIDTH-1:0];

  nios2_secure_memory_pio_edge_detect #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_detect (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync    (sync),
    .sel     (sel)
  );

  // Read mux and clear-mask decode; reads always see pre-write register values.
  always_comb begin
    rd_mux   = '0;
    edge_clr = '0;
    case (addr_e)
      PIO_ADDR_DATA:    rd_mux = 32'(sync);
      PIO_ADDR_DIR:     rd_mux = '0;
      PIO_ADDR_IRQMASK: rd_mux = 32'(irq_mask);
      PIO_ADDR_EDGECAP: rd_mux = 32'(edge_capture);
      default:          rd_mux = '0;
    endcase
    if (wr_en && addr_e == PIO_ADDR_EDGECAP) edge_clr = wdata;
  end

  // Register file, held read data and irq; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en && addr_e == PIO_ADDR_IRQMASK) irq_mask <= wdata;
      edge_capture <= (edge_capture & ~edge_clr) | sel;
      if (rd_en) readdata <= rd_mux;
      irq <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_nios2_secure_memory_button_pio.sv
// Bench for the button PIO: warm-up check on a rising-edge instance, a
// directed vector table, randomized traffic against a history-based model,
// and a mid-operation reset sequence.
module tb_nios2_secure_memory_button_pio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  in_port_r;
  logic [31:0] readdata_r;
  logic        irq_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios2_secure_memory_button_pio #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  nios2_secure_memory_button_pio #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port_r), .readdata(readdata_r), .irq(irq_r)
  );

  // Reference model: remembers the input value seen at each clock since reset.
  // An input value becomes visible S clocks after it is sampled; a falling
  // transition is captured only between two samples taken after reset.
  logic [7:0]  hist[$];
  logic [7:0]  m_ec, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  function automatic logic [7:0] hget(int ago);
    if (hist.size() > ago) return hist[hist.size()-1-ago];
    return 8'h00;
  endfunction

  task automatic model_update();
    logic [7:0] sync_v, prev_v, sel_v, clr_v, rdv;
    if (reset) begin
      hist.delete();
      m_ec = 0; m_mask = 0; m_rd = 0; m_irq = 0;
    end else begin
      hist.push_back(in_port);
      if (hist.size() > 8) void'(hist.pop_front());
      sync_v = hget(S);
      prev_v = hget(S + 1);
      sel_v  = (hist.size() >= S + 2) ? (prev_v & ~sync_v) : 8'h00;
      case (address)
        2'd0:    rdv = sync_v;
        2'd2:    rdv = m_mask;
        2'd3:    rdv = m_ec;
        default: rdv = 8'h00;
      endcase
      if (chipselect && !read_n) m_rd = {24'h0, rdv};
      clr_v = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
      m_irq = |(m_ec & m_mask);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
      m_ec = (m_ec & ~clr_v) | sel_v;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model_readdata", readdata, m_rd);
    chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic bus(logic cs, logic rn, logic wn, logic [1:0] a, logic [31:0] wd);
    chipselect = cs; read_n = rn; write_n = wn; address = a; writedata = wd;
  endtask

  typedef struct {
    logic        cs, rd_n, wr_n;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  function automatic vec_t mk(logic cs, logic rn, logic wn, logic [1:0] a, logic [31:0] wd,
                              logic [7:0] inp, logic c, logic [31:0] er, logic ei);
    vec_t v;
    v.cs = cs; v.rd_n = rn; v.wr_n = wn; v.addr = a; v.wd = wd; v.inp = inp;
    v.chk_rd = c; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  vec_t tbl[29];

  initial begin
    // idle=0,1,1 ; write=1,1,0 ; read=1,0,1 ; read+write=1,0,0
    tbl[0]  = mk(1,1,0,2,32'h08,8'hFF,0,0,0);
    tbl[1]  = mk(0,1,1,0,0,8'hF7,0,0,0);
    tbl[2]  = mk(0,1,1,0,0,8'hFF,0,0,0);
    tbl[3]  = mk(0,1,1,0,0,8'hFF,0,0,0);
    tbl[4]  = mk(1,0,1,3,0,8'hFF,1,32'h08,1);
    tbl[5]  = mk(0,1,1,0,0,8'hFF,1,32'h08,1);
    tbl[6]  = mk(0,1,1,0,0,8'hF7,0,0,1);
    tbl[7]  = mk(0,1,1,0,0,8'hFF,0,0,1);
    tbl[8]  = mk(1,1,0,3,32'h08,8'hFF,0,0,1);
    tbl[9]  = mk(1,0,1,3,0,8'hFF,1,32'h08,1);
    tbl[10] = mk(1,1,0,3,32'h08,8'hFF,0,0,1);
    tbl[11] = mk(1,0,1,3,0,8'hFF,1,32'h00,0);
    tbl[12] = mk(1,1,0,2,32'h00,8'h7E,0,0,0);
    tbl[13] = mk(0,1,1,0,0,8'hFF,0,0,0);
    tbl[14] = mk(0,1,1,0,0,8'hFF,0,0,0);
    tbl[15] = mk(0,1,1,0,0,8'hFF,0,0,0);
    tbl[16] = mk(1,0,1,3,0,8'hFF,1,32'h81,0);
    tbl[17] = mk(1,1,0,2,32'h80,8'hFF,0,0,0);
    tbl[18] = mk(0,1,1,0,0,8'hFF,0,0,1);
    tbl[19] = mk(1,1,0,3,32'hFF,8'hA5,0,0,1);
    tbl[20] = mk(0,1,1,0,0,8'hA5,0,0,0);
    tbl[21] = mk(0,1,1,0,0,8'hA5,0,0,0);
    tbl[22] = mk(1,0,1,0,0,8'hA5,1,32'hA5,0);
    tbl[23] = mk(1,0,1,1,0,8'hA5,1,32'h00,0);
    tbl[24] = mk(1,0,0,0,32'hFFFFFFFF,8'hA5,1,32'hA5,0);
    tbl[25] = mk(1,0,1,2,0,8'hA5,1,32'h80,0);
    tbl[26] = mk(1,0,1,3,0,8'hA5,1,32'h5A,0);
    tbl[27] = mk(1,0,0,2,32'h0F,8'hA5,1,32'h80,0);
    tbl[28] = mk(1,0,1,2,0,8'hA5,1,32'h0F,1);

    // Reset with all inputs high, then watch the rising-edge instance warm up.
    reset = 1'b1; in_port = 8'hFF; in_port_r = 8'hFF;
    bus(0,1,1,0,0);
    repeat (3) tick();
    chk("reset_readdata_r", readdata_r, 32'h0);
    chk("reset_irq_r", {31'b0, irq_r}, 32'h0);
    reset = 1'b0;
    bus(1,1,0,2,32'hFF);
    tick();
    bus(0,1,1,0,0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("warmup_irq_r", {31'b0, irq_r}, 32'h0);
    end
    bus(1,0,1,3,0);
    tick();
    chk("warmup_edgecap_r", readdata_r, 32'h0);
    bus(1,0,1,0,0);
    tick();
    chk("warmup_data_r", readdata_r, 32'hFF);

    // Directed vectors.
    for (int i = 0; i < 29; i++) begin
      bus(tbl[i].cs, tbl[i].rd_n, tbl[i].wr_n, tbl[i].addr, tbl[i].wd);
      in_port = tbl[i].inp;
      tick();
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
          2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      tick();
    end

    // Pending edges with irq high, then a one-cycle reset.
    in_port = 8'hFF;
    bus(1,1,0,2,32'hFF);
    tick();
    bus(0,1,1,0,0);
    repeat (4) tick();
    in_port = 8'h00;
    repeat (4) tick();
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    bus(1,0,1,3,0);
    tick();
    chk("pre_reset_edgecap", readdata, 32'hFF);
    bus(0,1,1,0,0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_irq", {31'b0, irq}, 32'h0);
    bus(1,0,1,2,0);
    tick();
    chk("post_reset_mask", readdata, 32'h0);
    bus(1,0,1,3,0);
    tick();
    chk("post_reset_edgecap", readdata, 32'h0);
    chk("post_reset_irq2", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
